cordic_iter: RTL

CORDIC_ITER -- requirements
Module: cordic_iter

---
 rtl/cordic_iter.sv | 119 +++++++++++
 1 files changed

// File: rtl/cordic_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, circular or hyperbolic.
// Operands are captured on the accept edge and the result is held until the consumer takes it.
module cordic_iter #(
  parameter int    W    = 34,
  parameter int    ITER = 20,
  parameter string MODE = "hyperbolic"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y,
  output logic                busy
);

  localparam bit CIRC = (MODE == "circular");
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       step_q, step_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] x_rot, y_rot;

  // Hyperbolic sequence repeats k=4 and k=13 so it converges; circular is simply k=step.
  function automatic logic [SW-1:0] shift_amt(input logic [CW-1:0] step);
    int s;
    int k;
    s = int'(step);
    if (CIRC)         k = s;
    else if (s <= 3)  k = s + 1;
    else if (s <= 13) k = s;
    else              k = s - 1;
    return SW'(k);
  endfunction

  // d = +1 when y is non-negative (including zero); sums wrap modulo 2^W.
  function automatic logic signed [W-1:0] rot_x(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y,
                                                input logic [SW-1:0]       k);
    logic signed [W-1:0] sy;
    sy = y >>> k;
    if (CIRC) return y[W-1] ? (x - sy) : (x + sy);
    else      return y[W-1] ? (x + sy) : (x - sy);
  endfunction

  function automatic logic signed [W-1:0] rot_y(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y,
                                                input logic [SW-1:0]       k);
    logic signed [W-1:0] sx;
    sx = x >>> k;
    return y[W-1] ? (y + sx) : (y - sx);
  endfunction

  always_comb begin
    x_rot = rot_x(x_q, y_q, shift_amt(step_q));
    y_rot = rot_y(x_q, y_q, shift_amt(step_q));
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = x_rot;
        y_d = y_rot;
        if (step_q == LAST) state_d = DONE;
        else                step_d  = step_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration state boundary: the x/y registers double as the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule
